// File: rtl/multiplier_block_buffer.sv
// ============================================================================
// Module   : multiplier_block_buffer
// Purpose  : Streaming 16x16 unsigned multiplier. It writes a block of 64
//            32-bit products into an external 64x32 two-port memory. On
//            request it replays the whole block in address order. Fill and
//            replay never overlap.
// Options  : MULT_OUTREG_EN - adds a product output register. Write latency
//            grows from 1 to 2 cycles after accept, and DRAIN lasts one
//            cycle longer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_block_buffer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN_mult,
  input  logic [15:0] mult_input0,
  input  logic [15:0] mult_input1,
  input  logic        EN_blockRead,
  input  logic [31:0] readMem_val,
  output logic        RDY_mult,
  output logic        EN_writeMem,
  output logic [5:0]  writeMem_addr,
  output logic [31:0] writeMem_val,
  output logic        EN_readMem,
  output logic [5:0]  readMem_addr,
  output logic        VALID_memVal,
  output logic [31:0] memVal_data
);

  localparam logic [5:0] LAST_ADDR = 6'd63;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_FULL  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        live_q;        // low during reset and for the first cycle after release
  logic [5:0]  fill_addr_q;   // address assigned to the next accepted pair
  logic [15:0] opa_q, opb_q;
  logic        s1_en_q;
  logic [5:0]  s1_addr_q;
  logic        rd_en_q;
  logic [5:0]  rd_addr_q;
  logic        valid_q;

  logic        w_accept;
  logic        w_last_write;
  logic        w_start_read;
  logic        w_read_done;
  logic [31:0] w_s1_prod;
  logic        w_wr_en;
  logic [5:0]  w_wr_addr;
  logic [31:0] w_wr_val;

  assign RDY_mult     = live_q && (state_q == S_FILL);
  assign w_accept     = EN_mult && RDY_mult;
  assign w_last_write = w_wr_en && (w_wr_addr == LAST_ADDR);
  assign w_start_read = (state_q == S_FULL) && EN_blockRead;
  // The last valid word is on the bus once the read strobe has dropped
  // while the valid flag is still high.
  assign w_read_done  = (state_q == S_READ) && !rd_en_q && valid_q;
  assign w_s1_prod    = {16'd0, opa_q} * {16'd0, opb_q};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (w_accept && (fill_addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (w_last_write) state_d = S_FULL;
      S_FULL:  if (w_start_read) state_d = S_READ;
      S_READ:  if (w_read_done) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Hold ready low for the first cycle after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  // Capture operands and assign write addresses on each accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_addr_q <= 6'd0;
      opa_q       <= 16'd0;
      opb_q       <= 16'd0;
      s1_en_q     <= 1'b0;
      s1_addr_q   <= 6'd0;
    end else begin
      s1_en_q <= w_accept;
      if (w_accept) begin
        opa_q       <= mult_input0;
        opb_q       <= mult_input1;
        s1_addr_q   <= fill_addr_q;
        fill_addr_q <= fill_addr_q + 6'd1;
      end
      if (w_read_done) fill_addr_q <= 6'd0;
    end
  end

`ifdef MULT_OUTREG_EN
  logic        s2_en_q;
  logic [5:0]  s2_addr_q;
  logic [31:0] prod_q;

  // Extra register stage on the product before it reaches the memory.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_en_q   <= 1'b0;
      s2_addr_q <= 6'd0;
      prod_q    <= 32'd0;
    end else begin
      s2_en_q <= s1_en_q;
      if (s1_en_q) begin
        s2_addr_q <= s1_addr_q;
        prod_q    <= w_s1_prod;
      end
    end
  end

  assign w_wr_en   = s2_en_q;
  assign w_wr_addr = s2_addr_q;
  assign w_wr_val  = prod_q;
`else
  assign w_wr_en   = s1_en_q;
  assign w_wr_addr = s1_addr_q;
  assign w_wr_val  = w_s1_prod;
`endif

  // Replay sequencer: 64 read strobes, with valid trailing by one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= 6'd0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= rd_en_q;
      if (w_start_read) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= 6'd0;
      end else if (rd_en_q) begin
        if (rd_addr_q == LAST_ADDR) rd_en_q   <= 1'b0;
        else                        rd_addr_q <= rd_addr_q + 6'd1;
      end
      if (w_read_done) rd_addr_q <= 6'd0;
    end
  end

  assign EN_writeMem   = w_wr_en;
  assign writeMem_addr = w_wr_addr;
  assign writeMem_val  = w_wr_val;
  assign EN_readMem    = rd_en_q;
  assign readMem_addr  = rd_addr_q;
  assign VALID_memVal  = valid_q;
  assign memVal_data   = readMem_val;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_block_buffer.sv
// ============================================================================
// Module   : tb_multiplier_block_buffer
// Purpose  : Self-checking bench for multiplier_block_buffer. It includes a
//            behavioural model of the external 64x32 memory and a reference
//            product table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_block_buffer;

`ifdef MULT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN_mult = 1'b0;
  logic [15:0] mult_input0 = 16'd0;
  logic [15:0] mult_input1 = 16'd0;
  logic        EN_blockRead = 1'b0;
  logic [31:0] readMem_val = 32'd0;
  logic        RDY_mult;
  logic        EN_writeMem;
  logic [5:0]  writeMem_addr;
  logic [31:0] writeMem_val;
  logic        EN_readMem;
  logic [5:0]  readMem_addr;
  logic        VALID_memVal;
  logic [31:0] memVal_data;

  logic [31:0] mem [64];
  logic [15:0] opa [64];
  logic [15:0] opb [64];
  logic [31:0] expv [64];
  int n_tests = 0;
  int n_fail  = 0;

  multiplier_block_buffer dut (
    .CLK(CLK), .RST(RST), .EN_mult(EN_mult),
    .mult_input0(mult_input0), .mult_input1(mult_input1),
    .EN_blockRead(EN_blockRead), .readMem_val(readMem_val),
    .RDY_mult(RDY_mult), .EN_writeMem(EN_writeMem),
    .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data)
  );

  always #5 CLK = ~CLK;

  // External two-port memory: registered read, write on the strobe.
  always @(posedge CLK) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem)  readMem_val <= mem[readMem_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Fill one block from opa/opb and check every write against the model.
  task automatic do_fill(input int idle_pct);
    int   sent, wrs, cyc;
    int   wq[$];
    logic exp_we, acc;
    sent = 0; wrs = 0; cyc = 0;
    for (int i = 0; i < 64; i++) expv[i] = {16'd0, opa[i]} * {16'd0, opb[i]};
    while (wrs < 64 && cyc < 1000) begin
      exp_we = 1'b0;
      if (wq.size() > 0) exp_we = (wq[0] == cyc);
      n_tests++;
      if (EN_writeMem !== exp_we) begin
        n_fail++;
        $display("FAIL fill_we cyc=%0d got %b want %b", cyc, EN_writeMem, exp_we);
      end
      if (exp_we) begin
        void'(wq.pop_front());
        n_tests++;
        if (writeMem_addr !== wrs[5:0]) begin
          n_fail++;
          $display("FAIL fill_addr got %0d want %0d", writeMem_addr, wrs);
        end
        n_tests++;
        if (writeMem_val !== expv[wrs]) begin
          n_fail++;
          $display("FAIL fill_val addr=%0d got %h want %h", wrs, writeMem_val, expv[wrs]);
        end
        wrs++;
      end
      n_tests++;
      if (RDY_mult !== (sent < 64)) begin
        n_fail++;
        $display("FAIL fill_rdy cyc=%0d got %b want %b", cyc, RDY_mult, (sent < 64));
      end
      n_tests++;
      if (EN_readMem !== 1'b0 || VALID_memVal !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_rd_idle got en=%b valid=%b want 0 0", EN_readMem, VALID_memVal);
      end
      if (sent < 64) begin
        EN_mult = ($urandom_range(0, 99) >= idle_pct);
        mult_input0 = EN_mult ? opa[sent] : 16'($urandom);
        mult_input1 = EN_mult ? opb[sent] : 16'($urandom);
      end else begin
        EN_mult = 1'($urandom_range(0, 1));
        mult_input0 = 16'($urandom);
        mult_input1 = 16'($urandom);
      end
      EN_blockRead = 1'($urandom_range(0, 1));
      acc = EN_mult && (sent < 64);
      @(posedge CLK); #1;
      if (acc) begin
        wq.push_back(cyc + LAT);
        sent++;
      end
      cyc++;
    end
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
    n_tests++;
    if (wrs != 64) begin
      n_fail++;
      $display("FAIL fill_timeout got %0d writes want 64", wrs);
    end
  endtask

  // From FULL: check EN_mult is ignored, then replay and check every word.
  task automatic do_replay();
    logic exp_en, exp_valid;
    for (int h = 0; h < 2; h++) begin
      n_tests++;
      if (RDY_mult !== 1'b0 || EN_writeMem !== 1'b0 || EN_readMem !== 1'b0) begin
        n_fail++;
        $display("FAIL full_idle got rdy=%b we=%b re=%b want 0 0 0", RDY_mult, EN_writeMem, EN_readMem);
      end
      EN_mult = 1'b1;
      mult_input0 = 16'($urandom);
      mult_input1 = 16'($urandom);
      @(posedge CLK); #1;
    end
    EN_mult = 1'b0;
    EN_blockRead = 1'b1;
    @(posedge CLK); #1;
    EN_blockRead = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      exp_en    = (k <= 64);
      exp_valid = (k >= 2 && k <= 65);
      n_tests++;
      if (EN_readMem !== exp_en) begin
        n_fail++;
        $display("FAIL rd_en k=%0d got %b want %b", k, EN_readMem, exp_en);
      end
      if (exp_en) begin
        n_tests++;
        if (readMem_addr !== 6'(k - 1)) begin
          n_fail++;
          $display("FAIL rd_addr k=%0d got %0d want %0d", k, readMem_addr, k - 1);
        end
      end
      n_tests++;
      if (VALID_memVal !== exp_valid) begin
        n_fail++;
        $display("FAIL rd_valid k=%0d got %b want %b", k, VALID_memVal, exp_valid);
      end
      if (exp_valid) begin
        n_tests++;
        if (memVal_data !== expv[k-2] || readMem_val !== expv[k-2]) begin
          n_fail++;
          $display("FAIL rd_data idx=%0d got %h/%h want %h", k - 2, memVal_data, readMem_val, expv[k-2]);
        end
      end
      n_tests++;
      if (RDY_mult !== (k >= 66)) begin
        n_fail++;
        $display("FAIL rd_rdy k=%0d got %b want %b", k, RDY_mult, (k >= 66));
      end
      if (k < 66) begin
        EN_mult = 1'($urandom_range(0, 1));
        EN_blockRead = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
      end
    end
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if (RDY_mult !== 1'b0 || EN_writeMem !== 1'b0 || EN_readMem !== 1'b0 || VALID_memVal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b we=%b re=%b v=%b want 0", RDY_mult, EN_writeMem, EN_readMem, VALID_memVal);
    end
    n_tests++;
    if (writeMem_addr !== 6'd0 || readMem_addr !== 6'd0 || writeMem_val !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data got wa=%0d ra=%0d wv=%h want 0", writeMem_addr, readMem_addr, writeMem_val);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    n_tests++;
    if (RDY_mult !== 1'b1 || EN_writeMem !== 1'b0 || EN_readMem !== 1'b0 || VALID_memVal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b we=%b re=%b v=%b want 1 0 0 0", RDY_mult, EN_writeMem, EN_readMem, VALID_memVal);
    end
  endtask

  task automatic test_fill_pattern();
    opa[0] = 16'd6; opb[0] = 16'd4;
    for (int i = 0; i < 63; i++) begin
      opa[i+1] = 16'(i);
      opb[i+1] = 16'd2;
    end
    do_fill(0);
    do_replay();
  endtask

  task automatic test_back_to_back();
    for (int k = 2; k <= 18; k += 2) begin
      opa[0] = 16'd6; opb[0] = 16'd4;
      for (int i = 0; i < 63; i++) begin
        opa[i+1] = 16'(i);
        opb[i+1] = 16'(k);
      end
      do_fill(0);
      do_replay();
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) begin
        opa[i] = 16'($urandom);
        opb[i] = 16'($urandom);
      end
      do_fill(40);
      do_replay();
    end
  endtask

  task automatic test_full_scale();
    EN_blockRead = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      n_tests++;
      if (EN_readMem !== 1'b0 || RDY_mult !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_blockread got re=%b rdy=%b want 0 1", EN_readMem, RDY_mult);
      end
    end
    EN_blockRead = 1'b0;
    for (int i = 0; i < 64; i++) begin
      opa[i] = (i % 4 == 3) ? 16'($urandom) : 16'hFFFF;
      opb[i] = (i % 4 == 3) ? 16'($urandom) : 16'hFFFF;
    end
    do_fill(20);
    n_tests++;
    if (expv[0] !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL full_scale_model got %h want fffe0001", expv[0]);
    end
    do_replay();
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 64; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
    end
    do_fill(0);
    EN_blockRead = 1'b1;
    @(posedge CLK); #1;
    EN_blockRead = 1'b0;
    repeat (20) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    n_tests++;
    if (EN_readMem !== 1'b0 || VALID_memVal !== 1'b0 || EN_writeMem !== 1'b0 || RDY_mult !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_strobes got re=%b v=%b we=%b rdy=%b want 0", EN_readMem, VALID_memVal, EN_writeMem, RDY_mult);
    end
    n_tests++;
    if (readMem_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL midrst_addr got %0d want 0", readMem_addr);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    n_tests++;
    if (RDY_mult !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rdy got %b want 1", RDY_mult);
    end
    for (int i = 0; i < 64; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
    end
    do_fill(25);
    do_replay();
  endtask

  initial begin
    test_reset();
    test_fill_pattern();
    test_back_to_back();
    test_random();
    test_full_scale();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiplier_block_buffer.md
# multiplier_block_buffer

Streaming 16×16 unsigned multiplier that writes 64 consecutive 32-bit products into an external 64×32 two-port memory (one read port, one write port), then replays the full block in order on request. It sits between a product-generating producer and a block-reading consumer. The block handshakes with both sides so that a fill and a replay never overlap.

## Interface
- Parameters: none. Depth is fixed at 64 words, data width at 32 bits, address width at 6 bits.
- CLK  in  1  single clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- EN_mult  in  1  offers operands this cycle; accepted only when RDY_mult=1.
- mult_input0, mult_input1  in  16 each  unsigned operands.
- EN_blockRead  in  1  request to replay the stored block; honoured only in FULL.
- readMem_val  in  32  external memory read-port data; 1-cycle registered latency after EN_readMem/readMem_addr.
- RDY_mult  out  1  block accepts operands.
- EN_writeMem  out  1  write strobe; active-high (memory chip-enable is its inverse).
- writeMem_addr  out  6  write address.
- writeMem_val  out  32  product to write.
- EN_readMem  out  1  read strobe; active-high.
- readMem_addr  out  6  read address.
- VALID_memVal  out  1  memVal_data and readMem_val hold a replayed word this cycle.
- memVal_data  out  32  replayed word; combinational pass-through of readMem_val.

## Operation
- States: FILL, DRAIN, FULL, READ. Reset enters FILL.
- FILL: RDY_mult=1. Each edge with EN_mult=1 accepts one operand pair, computes `mult_input0*mult_input1` as an unsigned 32-bit value with no truncation, and assigns the next write address.
  - Write addresses start at 0 after reset and after every replay, and increment by 1 per accept.
  - On the 64th accept (address 63), go to DRAIN.
  - EN_mult=0 idles with no state change.
- DRAIN: RDY_mult=0. Wait until the write for address 63 has been issued, then go to FULL.
- FULL: RDY_mult=0. EN_mult ignored. An edge with EN_blockRead=1 goes to READ.
- READ: EN_readMem=1 for exactly 64 consecutive cycles, with readMem_addr = 0,1,…,63.
  - VALID_memVal is EN_readMem delayed one cycle, so it is high for 64 consecutive cycles aligned with memory data.
  - After the cycle in which the last valid word (address 63) is presented, return to FILL with the address counters cleared.
- EN_blockRead in FILL or DRAIN is ignored; it is not latched. EN_blockRead during READ is ignored.
- There is no partial-block replay.

## Timing
- Reset values: RDY_mult=0 while RST=1; then 1 from the first cycle after RST deasserts. All other outputs are 0: EN_writeMem, EN_readMem, VALID_memVal, addresses, writeMem_val.
- Write latency, base build: operands are registered at the accept edge.
  - The next cycle drives EN_writeMem=1, writeMem_addr and writeMem_val = the registered product.
  - The memory captures the word on the following edge.
- RDY_mult falls in the cycle immediately after the 64th accept edge. A producer sampling RDY_mult each cycle therefore sees exactly 64 acceptances.
- Replay latency:
  - First EN_readMem cycle = the cycle after the EN_blockRead edge.
  - First VALID_memVal cycle = the cycle after that.
- RDY_mult re-asserts the cycle after VALID_memVal falls.
- RST mid-operation: abort immediately. Write and read strobes go to 0 asynchronously, counters clear, state returns to FILL. Memory contents are undefined to the consumer.

## Configuration
- MULT_OUTREG_EN defined: adds a product output register. Write latency becomes 2 cycles after accept, and DRAIN lasts one cycle longer. All other behaviour is identical.
- MULT_OUTREG_EN undefined: 1-cycle write latency as specified above.

## Test plan
- Reset, then RST low: RDY_mult=1 one cycle later; EN_writeMem=0, EN_readMem=0, VALID_memVal=0.
- Fill with pair (6,4), then pairs (i,2) for i=0..62, one per cycle:
  - 64 writes to addresses 0..63 with values 24, then 0,2,4,…,124.
  - RDY_mult drops right after the 64th accept.
- Pulse EN_blockRead in FULL: VALID_memVal high for 64 cycles; readMem_val and memVal_data sequence 24,0,2,…,124; RDY_mult returns after VALID_memVal falls.
- Repeat fill/replay for k=2,4,…,18 back-to-back: each replay returns 24 followed by i*k for i=0..62, with no stale words.
- Full-scale operands 0xFFFF×0xFFFF: stored and replayed value 0xFFFE0001. EN_mult in FULL and EN_blockRead in FILL are both ignored.
- RST asserted mid-READ: strobes drop immediately; after release RDY_mult=1 and the next fill writes from address 0.
